// File: rtl/emit_ctrl.sv
// Dose sequencer for the dispenser's emit down-counter: debounces the hand
// sensor, drives ld/clr/ACK, and enforces cooldown, re-arm and empty lockout.
module emit_ctrl #(
   parameter int DEBOUNCE   = 3,
   parameter int COOL_TICKS = 4,
   parameter int CAPACITY   = 20,
   parameter int DOSE_W     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hand_det,
   input  logic              tick,
   input  logic              eq_0,
   input  logic              refill,
   output logic              cnt0_ld,
   output logic              cnt0_clr,
   output logic              cnt0_ACK,
   output logic              busy,
   output logic              empty,
   output logic [DOSE_W-1:0] dose_left
);

   localparam int DEB_W  = $clog2(DEBOUNCE + 1);
   localparam int COOL_W = $clog2(COOL_TICKS + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_EMIT  = 3'd2;
   localparam logic [2:0] S_COOL  = 3'd3;
   localparam logic [2:0] S_EMPTY = 3'd4;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
   localparam logic [COOL_W-1:0] COOL_DONE = COOL_W'(COOL_TICKS);
   localparam logic [DOSE_W-1:0] DOSE_FULL = DOSE_W'(CAPACITY);

   logic [2:0]        state,    state_nxt;
   logic [DEB_W-1:0]  deb_cnt,  deb_nxt;
   logic [COOL_W-1:0] cool_cnt, cool_nxt;
   logic [DOSE_W-1:0] dose_nxt;
   logic              cool_done;

   assign cool_done = (cool_cnt == COOL_DONE);

   always_comb begin
      // NOTE: every signal written here gets its default first, so no path can infer a latch.
      state_nxt = state;
      deb_nxt   = deb_cnt;
      cool_nxt  = cool_cnt;
      dose_nxt  = dose_left;

      case (state)
         S_IDLE: begin
            if (dose_left == '0) begin
               state_nxt = S_EMPTY;
            end else if (!hand_det) begin
               deb_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = S_LOAD;
               deb_nxt   = '0;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         // Counter still reads 0 from the previous clear, so eq_0 is ignored here.
         S_LOAD: state_nxt = S_EMIT;
         S_EMIT: begin
            if (eq_0) begin
               state_nxt = S_COOL;
               if (dose_left != '0) dose_nxt = dose_left - 1'b1;
            end
         end
         S_COOL: begin
            if (tick && !cool_done) cool_nxt = cool_cnt + 1'b1;
            // A held hand keeps us here: no repeat dose without a fresh debounce.
            if (cool_done && !hand_det) begin
               cool_nxt  = '0;
               deb_nxt   = '0;
               state_nxt = (dose_left == '0) ? S_EMPTY : S_IDLE;
            end
         end
         S_EMPTY: if (refill) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // Refill overrides a coincident end-of-dose decrement.
      if (refill) dose_nxt = DOSE_FULL;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state     <= S_IDLE;
         deb_cnt   <= '0;
         cool_cnt  <= '0;
         dose_left <= DOSE_FULL;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_nxt;
         cool_cnt  <= cool_nxt;
         dose_left <= dose_nxt;
      end
   end

   // Commands show IDLE values while rst is high so the datapath clears during reset.
   always_comb begin
      cnt0_ld  = 1'b0;
      cnt0_clr = 1'b1;
      cnt0_ACK = 1'b0;
      busy     = 1'b0;
      empty    = 1'b0;
      if (!rst) begin
         case (state)
            S_LOAD: begin
               cnt0_ld  = 1'b1;
               cnt0_clr = 1'b0;
               busy     = 1'b1;
            end
            S_EMIT: begin
               cnt0_ld  = 1'b1;
               cnt0_clr = 1'b0;
               cnt0_ACK = tick;
               busy     = 1'b1;
            end
            S_COOL:  busy  = 1'b1;
            S_EMPTY: empty = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_emit_ctrl.sv
// Self-checking bench for emit_ctrl: two instances (capacity 20 and 2) share
// stimulus and are compared every cycle against a behavioural dispenser model.
module tb_emit_ctrl;

   localparam int LOAD_VAL   = 5;
   localparam int DEBOUNCE   = 3;
   localparam int COOL_TICKS = 4;

   typedef enum int {M_IDLE, M_LOAD, M_EMIT, M_COOL, M_EMPTY} mstate_t;

   logic clk = 1'b0;
   logic rst, hand_det, tick, refill, eq_a, eq_b;
   logic ld_a, clr_a, ack_a, busy_a, empty_a;
   logic ld_b, clr_b, ack_b, busy_b, empty_b;
   logic [4:0] dose_a;
   logic [1:0] dose_b;

   int n_pass  = 0;
   int n_total = 0;
   int n_ack_a, n_ld_a, n_ld_b, phase;
   bit rand_tick;

   // Reference model state, one entry per instance, plus the emulated datapath counters
   mstate_t m_st[2];
   int      m_dose[2], m_run[2], m_ticks[2], cnt[2];

   always #5 clk = ~clk;

   emit_ctrl #(.DEBOUNCE(DEBOUNCE), .COOL_TICKS(COOL_TICKS), .CAPACITY(20), .DOSE_W(5)) dut_a (
      .clk(clk), .rst(rst), .hand_det(hand_det), .tick(tick), .eq_0(eq_a), .refill(refill),
      .cnt0_ld(ld_a), .cnt0_clr(clr_a), .cnt0_ACK(ack_a), .busy(busy_a), .empty(empty_a),
      .dose_left(dose_a)
   );

   emit_ctrl #(.DEBOUNCE(DEBOUNCE), .COOL_TICKS(COOL_TICKS), .CAPACITY(2), .DOSE_W(2)) dut_b (
      .clk(clk), .rst(rst), .hand_det(hand_det), .tick(tick), .eq_0(eq_b), .refill(refill),
      .cnt0_ld(ld_b), .cnt0_clr(clr_b), .cnt0_ACK(ack_b), .busy(busy_b), .empty(empty_b),
      .dose_left(dose_b)
   );

   function automatic int cap(input int i);
      return (i == 0) ? 20 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Expected {ld, clr, ACK, busy, empty} from the model's dispenser phase
   function automatic logic [4:0] exp_cmds(input int i, input logic t, input logic rs);
      logic dosing, ld, clr, ack, bsy, emp;
      dosing = (m_st[i] == M_LOAD) || (m_st[i] == M_EMIT);
      ld  = !rs && dosing;
      clr = rs || !dosing;
      ack = !rs && (m_st[i] == M_EMIT) && t;
      bsy = !rs && (m_st[i] != M_IDLE) && (m_st[i] != M_EMPTY);
      emp = !rs && (m_st[i] == M_EMPTY);
      return {ld, clr, ack, bsy, emp};
   endfunction

   task automatic check_dut(input int i, input logic t, input logic rs);
      logic [4:0] c;
      c = exp_cmds(i, t, rs);
      if (i == 0) begin
         check("ld_a",    32'(ld_a),    32'(c[4]));
         check("clr_a",   32'(clr_a),   32'(c[3]));
         check("ack_a",   32'(ack_a),   32'(c[2]));
         check("busy_a",  32'(busy_a),  32'(c[1]));
         check("empty_a", 32'(empty_a), 32'(c[0]));
         check("dose_a",  32'(dose_a),  32'(m_dose[0]));
      end else begin
         check("ld_b",    32'(ld_b),    32'(c[4]));
         check("clr_b",   32'(clr_b),   32'(c[3]));
         check("ack_b",   32'(ack_b),   32'(c[2]));
         check("busy_b",  32'(busy_b),  32'(c[1]));
         check("empty_b", 32'(empty_b), 32'(c[0]));
         check("dose_b",  32'(dose_b),  32'(m_dose[1]));
      end
   endtask

   task automatic model_next(input int i, input logic h, input logic t, input logic r, input logic rs);
      logic [4:0] c;
      bit         eq;
      eq = (cnt[i] == 0);
      c  = exp_cmds(i, t, rs);
      // Datapath counter: clear, load when idle-at-zero, count down on ACK
      if (c[3])                     cnt[i] = 0;
      else if (c[4] && cnt[i] == 0) cnt[i] = LOAD_VAL;
      else if (c[4] && c[2])        cnt[i] = cnt[i] - 1;

      if (rs) begin
         m_st[i] = M_IDLE; m_dose[i] = cap(i); m_run[i] = 0; m_ticks[i] = 0;
         return;
      end
      case (m_st[i])
         M_IDLE: begin
            if (m_dose[i] == 0) m_st[i] = M_EMPTY;
            else if (!h) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == DEBOUNCE) begin m_st[i] = M_LOAD; m_run[i] = 0; end
            end
         end
         M_LOAD: m_st[i] = M_EMIT;
         M_EMIT: if (eq) begin
            m_st[i] = M_COOL;
            if (m_dose[i] > 0) m_dose[i] = m_dose[i] - 1;
         end
         M_COOL: begin
            if (m_ticks[i] >= COOL_TICKS && !h) begin
               m_st[i]    = (m_dose[i] == 0) ? M_EMPTY : M_IDLE;
               m_ticks[i] = 0;
               m_run[i]   = 0;
            end else if (t && m_ticks[i] < COOL_TICKS) begin
               m_ticks[i]++;
            end
         end
         M_EMPTY: if (r) m_st[i] = M_IDLE;
         default: ;
      endcase
      if (r) m_dose[i] = cap(i);
   endtask

   // One clock cycle: drive inputs, check at negedge, advance model, settle after posedge
   task automatic cycle(input logic h, input logic r, input logic rs);
      logic t;
      t = rand_tick ? ($urandom_range(0, 2) == 0) : (phase == 3);
      phase = (phase + 1) % 4;
      hand_det = h; refill = r; rst = rs; tick = t;
      @(negedge clk);
      check_dut(0, t, rs);
      check_dut(1, t, rs);
      n_ack_a += int'(ack_a);
      n_ld_a  += int'(ld_a && !clr_a && !ack_a && !busy_a ? 1'b0 : (ld_a && m_st[0] == M_LOAD));
      n_ld_b  += int'(ld_b && m_st[1] == M_LOAD);
      model_next(0, h, t, r, rs);
      model_next(1, h, t, r, rs);
      @(posedge clk);
      #1;
      eq_a = (cnt[0] == 0);
      eq_b = (cnt[1] == 0);
   endtask

   task automatic run_dose();
      repeat (DEBOUNCE) cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 200 && m_st[0] != M_IDLE; k++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic h;
      rst = 1'b1; hand_det = 1'b0; tick = 1'b0; refill = 1'b0;
      eq_a = 1'b1; eq_b = 1'b1; phase = 0; rand_tick = 1'b0;
      n_ack_a = 0; n_ld_a = 0; n_ld_b = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         m_st[i] = M_IDLE; m_dose[i] = cap(i); m_run[i] = 0; m_ticks[i] = 0; cnt[i] = 0;
      end

      // Reset held, then idle
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, 1'b0);

      // Nominal dose
      n_ack_a = 0;
      run_dose();
      check("nominal_idle", 32'(busy_a), 32'd0);
      check("nominal_acks", 32'(n_ack_a), 32'(LOAD_VAL));
      check("nominal_dose", 32'(dose_a), 32'd19);

      // Debounce glitch: 2 high, 1 low, 2 high
      n_ld_a = 0;
      cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      check("glitch_no_load", 32'(n_ld_a), 32'd0);
      check("glitch_clr", 32'(clr_a), 32'd1);

      // Re-arm: hand held through cooldown
      n_ld_a = 0;
      repeat (DEBOUNCE + 60) cycle(1'b1, 1'b0, 1'b0);
      check("rearm_held_busy", 32'(busy_a), 32'd1);
      check("rearm_one_load", 32'(n_ld_a), 32'd1);
      cycle(1'b0, 1'b0, 1'b0);
      check("rearm_exit_idle", 32'(busy_a), 32'd0);
      check("rearm_dose", 32'(dose_a), 32'd18);
      check("b_empty", 32'(empty_b), 32'd1);
      check("b_dose_zero", 32'(dose_b), 32'd0);

      // Empty lockout ignores the hand; refill restores
      n_ld_b = 0;
      repeat (10) cycle(1'b1, 1'b0, 1'b0);
      repeat (80) cycle(1'b0, 1'b0, 1'b0);
      check("b_lockout_no_load", 32'(n_ld_b), 32'd0);
      check("b_still_empty", 32'(empty_b), 32'd1);
      cycle(1'b0, 1'b1, 1'b0);
      check("b_refill_not_empty", 32'(empty_b), 32'd0);
      check("b_refill_dose", 32'(dose_b), 32'd2);
      check("a_refill_dose", 32'(dose_a), 32'd20);

      // Reset during EMIT after 2 ticks
      run_dose();
      n_ack_a = 0;
      repeat (DEBOUNCE) cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 100 && n_ack_a < 2; k++) cycle(1'b0, 1'b0, 1'b0);
      check("pre_reset_busy", 32'(busy_a), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      check("post_reset_busy", 32'(busy_a), 32'd0);
      check("post_reset_clr", 32'(clr_a), 32'd1);
      check("post_reset_dose", 32'(dose_a), 32'd20);

      // Refill colliding with the end-of-dose decrement
      repeat (DEBOUNCE) cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 100 && !(m_st[0] == M_EMIT && cnt[0] == 0); k++) cycle(1'b0, 1'b0, 1'b0);
      check("collide_emit", 32'(ld_a), 32'd1);
      cycle(1'b0, 1'b1, 1'b0);
      check("collide_dose", 32'(dose_a), 32'd20);
      check("collide_cool", 32'(busy_a & ~ld_a), 32'd1);
      repeat (30) cycle(1'b0, 1'b0, 1'b0);

      // Randomized traffic
      rand_tick = 1'b1;
      h = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0) h = ~h;
         cycle(h, ($urandom_range(0, 59) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
